modexp_ctrl: RTL and testbench

Sequencer that drives the shared 64-limb big-integer multiplier (Montgomery multiply, `dst = a·b·R⁻¹ mod N`) through a left-to-right square-and-multiply modular exponentiation. It reads the exponent word by word from exponent RAM and issues one multiply command at a time over a start/done handshake. It reports completion to the RSA top level. It moves no operand data; buffer contents and address generation belong to the multiplier.

---
 rtl/rsa_pkg.sv | 27 ++
 rtl/modexp_ctrl_if.sv | 31 +++
 rtl/modexp_ctrl.sv | 126 ++++++++++++
 tb/tb_modexp_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rsa_pkg.sv
// rtl/rsa_pkg.sv - shared RSA datapath types: buffer ids, modexp states, limb geometry
package rsa_pkg;

    localparam int LIMBS  = 64;
    localparam int LIMB_W = 64;

    typedef enum logic [1:0] {
        BUF_BASE = 2'd0,
        BUF_ACC  = 2'd1,
        BUF_ONE  = 2'd2,
        BUF_TMP  = 2'd3
    } buf_id_t;

    typedef enum logic [3:0] {
        S_IDLE,
        S_INIT_ISSUE,
        S_INIT_WAIT,
        S_FETCH,
        S_FETCH_WAIT,
        S_SQ_ISSUE,
        S_SQ_WAIT,
        S_MUL_ISSUE,
        S_MUL_WAIT,
        S_DONE
    } modexp_state_t;

endpackage

// File: rtl/modexp_ctrl_if.sv
// rtl/modexp_ctrl_if.sv - modexp sequencer bus: run control, exponent RAM port, multiplier command
interface modexp_ctrl_if
    import rsa_pkg::*;
#(
    parameter int EXP_W  = 12,
    parameter int ADDR_W = 6
);
    logic              start;
    logic [EXP_W-1:0]  expLen;
    logic [ADDR_W-1:0] eAddr;
    logic [LIMB_W-1:0] eData;
    logic              mulStart;
    buf_id_t           mulSelA;
    buf_id_t           mulSelB;
    buf_id_t           mulSelDst;
    logic              mulDone;
    logic              busy;
    logic              done;
    logic [EXP_W-1:0]  sqCount;
    logic [EXP_W-1:0]  mulCount;

    modport master (
        input  start, expLen, eData, mulDone,
        output eAddr, mulStart, mulSelA, mulSelB, mulSelDst, busy, done, sqCount, mulCount
    );

    modport slave (
        output start, expLen, eData, mulDone,
        input  eAddr, mulStart, mulSelA, mulSelB, mulSelDst, busy, done, sqCount, mulCount
    );
endinterface

// File: rtl/modexp_ctrl.sv
// rtl/modexp_ctrl.sv - left-to-right square-and-multiply sequencer for the Montgomery multiplier
module modexp_ctrl
    import rsa_pkg::*;
#(
    parameter int EXP_W  = 12,
    parameter int ADDR_W = 6
) (
    input  logic          clk,
    input  logic          reset,
    modexp_ctrl_if.master bus
);

    modexp_state_t     state;
    logic [EXP_W-1:0]  len;
    logic [EXP_W-1:0]  bit_idx;
    logic [LIMB_W-1:0] word;

    logic [EXP_W-1:0] next_idx;
    logic [EXP_W-1:0] first_idx;
    logic             bit_set;
    logic             advance;

    always_comb begin
        next_idx  = bit_idx - EXP_W'(1);
        first_idx = len - EXP_W'(2);
        bit_set   = word[bit_idx[5:0]];
        // Leave the current bit: after a zero-bit square or after the multiply.
        advance   = bus.mulDone && ((state == S_SQ_WAIT && !bit_set) || state == S_MUL_WAIT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            len           <= '0;
            bit_idx       <= '0;
            word          <= '0;
            bus.eAddr     <= '0;
            bus.mulStart  <= 1'b0;
            bus.mulSelA   <= BUF_BASE;
            bus.mulSelB   <= BUF_BASE;
            bus.mulSelDst <= BUF_BASE;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.sqCount   <= '0;
            bus.mulCount  <= '0;
        end else begin
            bus.mulStart <= 1'b0;
            bus.done     <= 1'b0;
            case (state)
                S_IDLE: if (bus.start) begin
                    len           <= bus.expLen;
                    bus.sqCount   <= '0;
                    bus.mulCount  <= '0;
                    bus.busy      <= 1'b1;
                    bus.mulStart  <= 1'b1;
                    // A zero-length exponent yields R mod N, i.e. Montgomery one.
                    bus.mulSelA   <= (bus.expLen == '0) ? BUF_ONE : BUF_BASE;
                    bus.mulSelB   <= BUF_ONE;
                    bus.mulSelDst <= BUF_ACC;
                    state         <= S_INIT_ISSUE;
                end
                S_INIT_ISSUE: state <= S_INIT_WAIT;
                S_INIT_WAIT: if (bus.mulDone) begin
                    if (len <= EXP_W'(1)) begin
                        bus.done <= 1'b1;
                        bus.busy <= 1'b0;
                        state    <= S_DONE;
                    end else begin
                        bit_idx   <= first_idx;
                        bus.eAddr <= first_idx[ADDR_W+5:6];
                        state     <= S_FETCH;
                    end
                end
                S_FETCH: state <= S_FETCH_WAIT;
                S_FETCH_WAIT: begin
                    word          <= bus.eData;
                    bus.mulStart  <= 1'b1;
                    bus.mulSelA   <= BUF_ACC;
                    bus.mulSelB   <= BUF_ACC;
                    bus.mulSelDst <= BUF_ACC;
                    state         <= S_SQ_ISSUE;
                end
                S_SQ_ISSUE: begin
                    bus.sqCount <= bus.sqCount + EXP_W'(1);
                    state       <= S_SQ_WAIT;
                end
                S_SQ_WAIT: if (bus.mulDone && bit_set) begin
                    bus.mulStart  <= 1'b1;
                    bus.mulSelA   <= BUF_ACC;
                    bus.mulSelB   <= BUF_BASE;
                    bus.mulSelDst <= BUF_ACC;
                    state         <= S_MUL_ISSUE;
                end
                S_MUL_ISSUE: begin
                    bus.mulCount <= bus.mulCount + EXP_W'(1);
                    state        <= S_MUL_WAIT;
                end
                S_MUL_WAIT: ;
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase

            if (advance) begin
                if (bit_idx == '0) begin
                    bus.done <= 1'b1;
                    bus.busy <= 1'b0;
                    state    <= S_DONE;
                end else begin
                    bit_idx <= next_idx;
                    // Crossing from bit 0 of a word into bit 63 of the next lower word.
                    if (bit_idx[5:0] == 6'd0) begin
                        bus.eAddr <= next_idx[ADDR_W+5:6];
                        state     <= S_FETCH;
                    end else begin
                        bus.mulStart  <= 1'b1;
                        bus.mulSelA   <= BUF_ACC;
                        bus.mulSelB   <= BUF_ACC;
                        bus.mulSelDst <= BUF_ACC;
                        state         <= S_SQ_ISSUE;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_modexp_ctrl.sv
// tb/tb_modexp_ctrl.sv - directed vector bench for modexp_ctrl with random-latency multiplier model
module tb_modexp_ctrl;
    import rsa_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    modexp_ctrl_if #(.EXP_W(12), .ADDR_W(6)) bus ();
    modexp_ctrl #(.EXP_W(12), .ADDR_W(6)) dut (.clk(clk), .reset(reset), .bus(bus));

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [63:0] ram [64];
    always @(posedge clk) bus.eData <= ram[bus.eAddr];

    typedef struct {
        int          len;
        logic [63:0] w0, w1, w2;
        int          sq, mul, ncmd, nf;
        int          f0, f1, f2;
    } vec_t;
    vec_t vecs [7];

    logic [5:0] cmd_q [$];
    logic [5:0] exp_q [$];
    int fetch_q [$];
    int done_cnt = 0;
    bit outstanding = 0;
    int lat_cnt = 0;
    int last_done_cyc = 0;
    bit have_done = 0;
    bit fetched_since = 0;
    bit expect_first = 0;
    int start_cyc = 0;
    bit spur_en = 1;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Multiplier model and protocol monitor; spurious mulDone only while nothing is outstanding.
    always @(negedge clk) begin
        bus.mulDone = 1'b0;
        if (reset) begin
            outstanding = 0;
            have_done = 0;
            fetched_since = 0;
        end else begin
            if (dut.state == S_FETCH) begin
                fetch_q.push_back(int'(bus.eAddr));
                fetched_since = 1;
            end
            if (bus.mulStart) begin
                chk("one_outstanding", longint'(outstanding), 0);
                if (expect_first) begin
                    chk("start_to_mulStart", cyc - start_cyc, 1);
                    expect_first = 0;
                end else if (have_done) begin
                    chk("mulDone_to_mulStart", cyc - last_done_cyc, fetched_since ? 3 : 1);
                end
                cmd_q.push_back({bus.mulSelA, bus.mulSelB, bus.mulSelDst});
                outstanding = 1;
                lat_cnt = int'($urandom_range(1, 40)) - 1;
            end else if (outstanding) begin
                if (lat_cnt == 0) begin
                    bus.mulDone = 1'b1;
                    outstanding = 0;
                    last_done_cyc = cyc;
                    have_done = 1;
                    fetched_since = 0;
                end else begin
                    lat_cnt--;
                end
            end else if (spur_en && $urandom_range(0, 2) == 0) begin
                bus.mulDone = 1'b1;
            end
            if (bus.done) begin
                done_cnt++;
                chk("done_after_last_mulDone", cyc - last_done_cyc, 1);
                chk("busy_low_with_done", longint'(bus.busy), 0);
                have_done = 0;
            end
        end
    end

    task automatic build_expected(input int len);
        exp_q.delete();
        if (len == 0) exp_q.push_back({BUF_ONE, BUF_ONE, BUF_ACC});
        else          exp_q.push_back({BUF_BASE, BUF_ONE, BUF_ACC});
        for (int i = len - 2; i >= 0; i--) begin
            logic [63:0] w;
            w = ram[i >> 6];
            exp_q.push_back({BUF_ACC, BUF_ACC, BUF_ACC});
            if (w[i & 63]) exp_q.push_back({BUF_ACC, BUF_BASE, BUF_ACC});
        end
    endtask

    task automatic load(input vec_t v);
        for (int k = 0; k < 64; k++) ram[k] = 64'h0;
        ram[0] = v.w0;
        ram[1] = v.w1;
        ram[2] = v.w2;
        cmd_q.delete();
        fetch_q.delete();
        build_expected(v.len);
    endtask

    task automatic kick(input int len);
        @(negedge clk);
        bus.expLen = 12'(len);
        bus.start = 1'b1;
        start_cyc = cyc;
        expect_first = 1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int d0;
        d0 = done_cnt;
        for (int k = 0; k < 20000 && done_cnt == d0; k++) @(posedge clk);
        chk({tag, "_done_reached"}, done_cnt - d0, 1);
        @(negedge clk);
        #1;
    endtask

    task automatic check_run(input vec_t v, input string tag);
        int bad;
        int fe [3];
        bad = 0;
        fe[0] = v.f0;
        fe[1] = v.f1;
        fe[2] = v.f2;
        chk({tag, "_sqCount"}, bus.sqCount, v.sq);
        chk({tag, "_mulCount"}, bus.mulCount, v.mul);
        chk({tag, "_cmd_count"}, cmd_q.size(), v.ncmd);
        for (int k = 0; k < cmd_q.size() && k < exp_q.size(); k++)
            if (cmd_q[k] !== exp_q[k]) bad++;
        chk({tag, "_cmd_seq_mismatches"}, bad, 0);
        chk({tag, "_fetch_count"}, fetch_q.size(), v.nf);
        for (int k = 0; k < fetch_q.size() && k < 3; k++)
            chk({tag, "_fetch_addr"}, fetch_q[k], fe[k]);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        load(v);
        kick(v.len);
        wait_done(tag);
        check_run(v, tag);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.expLen = '0;
        bus.mulDone = 1'b0;
        for (int k = 0; k < 64; k++) ram[k] = 64'h0;

        vecs[0] = '{len: 0,   w0: 64'h0, w1: 64'h0, w2: 64'h0, sq: 0,   mul: 0,  ncmd: 1,   nf: 0, f0: -1, f1: -1, f2: -1};
        vecs[1] = '{len: 1,   w0: 64'h1, w1: 64'h0, w2: 64'h0, sq: 0,   mul: 0,  ncmd: 1,   nf: 0, f0: -1, f1: -1, f2: -1};
        vecs[2] = '{len: 4,   w0: 64'hB, w1: 64'h0, w2: 64'h0, sq: 3,   mul: 2,  ncmd: 6,   nf: 1, f0: 0,  f1: -1, f2: -1};
        vecs[3] = '{len: 130, w0: 64'hFFFF_FFFF_FFFF_FFFF, w1: 64'h0, w2: 64'h2,
                    sq: 129, mul: 64, ncmd: 194, nf: 3, f0: 2, f1: 1, f2: 0};
        vecs[4] = '{len: 64,  w0: 64'h8000_0000_0000_0001, w1: 64'h0, w2: 64'h0,
                    sq: 63,  mul: 1,  ncmd: 65,  nf: 1, f0: 0,  f1: -1, f2: -1};
        vecs[5] = '{len: 65,  w0: 64'hAAAA_AAAA_AAAA_AAAA, w1: 64'h1, w2: 64'h0,
                    sq: 64,  mul: 32, ncmd: 97,  nf: 1, f0: 0,  f1: -1, f2: -1};
        vecs[6] = '{len: 66,  w0: 64'h0, w1: 64'h2, w2: 64'h0, sq: 65, mul: 0, ncmd: 66, nf: 2, f0: 1, f1: 0, f2: -1};

        repeat (3) @(negedge clk);
        #1;
        chk("reset_eAddr", bus.eAddr, 0);
        chk("reset_mulStart", bus.mulStart, 0);
        chk("reset_sels", {bus.mulSelA, bus.mulSelB, bus.mulSelDst}, 0);
        chk("reset_busy_done", {bus.busy, bus.done}, 0);
        chk("reset_counts", {bus.sqCount, bus.mulCount}, 0);
        @(negedge clk);
        reset = 1'b0;

        for (int n = 0; n < 7; n++) run_vec(vecs[n], $sformatf("vec%0d", n));

        // Reset while waiting on a square, then a clean rerun.
        begin
            vec_t v;
            v = vecs[4];
            load(v);
            kick(v.len);
            for (int k = 0; k < 20000 && !(dut.state == S_SQ_WAIT && bus.sqCount >= 5); k++) begin
                @(negedge clk);
                #1;
            end
            chk("reached_sq_wait", longint'(dut.state == S_SQ_WAIT), 1);
            reset = 1'b1;
            #1;
            chk("abort_state_idle", longint'(dut.state == S_IDLE), 1);
            chk("abort_eAddr_mulStart", {bus.eAddr, bus.mulStart}, 0);
            chk("abort_sels", {bus.mulSelA, bus.mulSelB, bus.mulSelDst}, 0);
            chk("abort_busy_done", {bus.busy, bus.done}, 0);
            chk("abort_counts", {bus.sqCount, bus.mulCount}, 0);
            @(negedge clk);
            reset = 1'b0;
            run_vec(vecs[2], "after_reset");
        end

        // start pulses mid-run and in the done cycle must be ignored.
        begin
            int n_cmd;
            load(vecs[2]);
            kick(vecs[2].len);
            repeat (10) @(negedge clk);
            bus.expLen = 12'd0;
            bus.start = 1'b1;
            @(negedge clk);
            bus.start = 1'b0;
            for (int k = 0; k < 20000 && !bus.done; k++) begin
                @(negedge clk);
                #1;
            end
            chk("ignore_done_seen", bus.done, 1);
            bus.start = 1'b1;
            @(negedge clk);
            bus.start = 1'b0;
            n_cmd = cmd_q.size();
            repeat (5) @(negedge clk);
            #1;
            chk("ignore_busy_stays_low", bus.busy, 0);
            chk("ignore_no_new_cmd", cmd_q.size(), n_cmd);
            check_run(vecs[2], "ignore");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
